divider_issue_ctrl: RTL
=======================

// Module: divider_issue_ctrl
// PURPOSE
//   Upstream issue stage for divider_top. Accepts divide requests on a valid/ready handshake and queues them in a FIFO.
//   Issues at most one request per cycle into the fixed-latency, no-backpressure divider pipeline.
//   Issue is gated by a credit counter, so results can never overrun the downstream result buffer.
// PARAMETERS
//   DIVIDEND_WIDTH  8  width of dividend / quotient path
//   DIVIDER_WIDTH   8  width of divisor / remainder path
//   FIFO_DEPTH      8  request queue entries; power of 2, >=2
//   CREDITS         16 downstream result-buffer slots; initial credit count
// PORTS
//   in_clk            in   1                    clock; all logic on rising edge
//   in_reset          in   1                    synchronous reset, active-high
//   in_req_valid      in   1                    request present
//   out_req_ready     out  1                    request accepted when valid&&ready
//   in_dividend       in   DIVIDEND_WIDTH       request dividend
//   in_divider        in   DIVIDER_WIDTH        request divisor
//   in_flush          in   1                    1-cycle pulse; discard all queued requests
//   in_credit_return  in   1                    1-cycle pulse per result consumed downstream
//   out_data_valid    out  1                    issue strobe to divider_top.in_data_valid
//   out_dividend      out  DIVIDEND_WIDTH       to divider_top.in_dividend
//   out_divider       out  DIVIDER_WIDTH        to divider_top.in_divider
//   out_zero_flag     out  1                    issued item had divisor 0 (see CONFIGURATION)
//   out_fifo_count    out  $clog2(FIFO_DEPTH)+1 queued entries
//   out_credit_count  out  $clog2(CREDITS)+1    available credits
//   out_credit_err    out  1                    sticky: credit returned while count==CREDITS
// BEHAVIOUR
//   Reset: all outputs 0 except out_credit_count=CREDITS. FIFO is emptied, state=S_IDLE. Reset overrides flush/handshake.
//   out_req_ready = !full && state!=S_FLUSH. There is no push pass-through when full.
//     Push and pop in the same cycle are legal when not full; count is unchanged.
//   Issue condition (registered): fifo nonempty && credit>0 && state!=S_FLUSH.
//     When true, the next edge loads out_* from the FIFO head, sets out_data_valid=1 for exactly one cycle, and pops.
//     When false, out_data_valid=0 and out_dividend/out_divider hold their last values.
//   Latency: a request accepted at edge N, into an empty FIFO with credit>0, has out_data_valid high after edge N+1.
//   Issue order is strict FIFO. Sustained throughput is 1/cycle while credits last.
//   Credits: -1 on issue, +1 on in_credit_return. Simultaneous issue and return leaves the count unchanged.
//     A return at count==CREDITS saturates the count and sets out_credit_err (cleared only by reset).
//   FSM:
//     S_IDLE  : fifo empty. ->S_ISSUE on a push; ->S_FLUSH on in_flush.
//     S_ISSUE : issuing. ->S_STALL if credit reaches 0 with entries left;
//               ->S_IDLE when the last entry pops with no push; ->S_FLUSH on in_flush.
//     S_STALL : nonempty, credit 0, out_data_valid=0. ->S_ISSUE on credit return; ->S_FLUSH on in_flush.
//     S_FLUSH : single cycle. FIFO pointers are cleared, no push, no issue. ->S_IDLE unconditionally.
//   in_flush takes priority over push and issue in the same cycle. A request offered that cycle is not accepted.
//   Flush does not touch the credit count: in-flight divider results still return credits.
// CONFIGURATION
//   DIV_ZERO_GUARD_EN defined:
//     A head entry with divisor 0 is issued with out_divider forced to 1 and out_zero_flag=1 with out_data_valid.
//     Credit is still consumed.
//   Not defined: divisor is issued unchanged and out_zero_flag is tied 0.
// STRUCTURE
//   Shared package header divider_pkg.vh holds:
//     default DIVIDEND_WIDTH/DIVIDER_WIDTH;
//     state encodings S_IDLE=2'd0, S_ISSUE=2'd1, S_STALL=2'd2, S_FLUSH=2'd3;
//     a clog2 helper.
//   Sub-module sync_fifo (WIDTH=DIVIDEND_WIDTH+DIVIDER_WIDTH, DEPTH=FIFO_DEPTH) provides:
//     extra-bit wrap pointers, full/empty/count, and synchronous clear for flush.
//   The FSM, credit counter and issue register live in this module.
// TESTING
//   Compare each out_data_valid beat against a FIFO-order reference model; reset in mid-burst, then check all outputs/credits.
//   1 req 200/7, credit 16 -> out_data_valid exactly one cycle after acceptance edge; 200,7 issued; credit 15.
//   CREDITS=16, no returns, 20 back-to-back reqs:
//     16 consecutive issues, then S_STALL with credit 0 and 4 queued.
//     One in_credit_return pulse -> exactly one more issue.
//   Fill FIFO (8), hold valid:
//     out_req_ready=0, count stays 8.
//     Simultaneous issue and new req -> ready high again next cycle, count 8.
//   5 queued, in_flush with in_req_valid=1 -> nothing accepted; count 0 after 1 cycle; no out_data_valid; credits unchanged.
//   Credit return at count 16 -> count stays 16, out_credit_err=1 until reset.
//   Req divisor 0: with DIV_ZERO_GUARD_EN -> out_divider=1, out_zero_flag=1; without -> out_divider=0, flag 0.

Source files
------------

// File: rtl/divider_issue_ctrl_pkg.sv
// Shared definitions for the divider issue stage: default datapath widths,
// FSM state encoding and a constant-width helper.
// Latency: n/a (package). Backpressure: n/a (package).
package divider_issue_ctrl_pkg;

  localparam int DIVIDEND_WIDTH_DEF = 8;
  localparam int DIVIDER_WIDTH_DEF  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_STALL = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  // Ceiling log2 usable in parameter/localparam expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/divider_issue_ctrl_sync_fifo.sv
// Synchronous request queue with extra-bit wrap pointers and a clear for flush.
// Latency: push visible at head one edge later; head is combinational from storage.
// Backpressure: push ignored when full, pop ignored when empty; caller gates both.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   clear             synchronous pointer clear (flush); wins over push/pop
//   push, push_data   enqueue one entry
//   pop               dequeue the head entry
//   head              current head entry
//   full, empty       occupancy flags
//   count             number of queued entries (0..DEPTH)
module divider_issue_ctrl_sync_fifo
  import divider_issue_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only observable between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  // Same slot index but different lap bit means the writer is a full lap ahead.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/divider_issue_ctrl.sv
// Issue stage for divider_top: queues requests and issues one per cycle, gated by result-buffer credits.
// Latency: request accepted at edge N into an empty queue with credit is issued (out_data_valid) after edge N+1.
// Backpressure: out_req_ready drops when the queue is full or during the flush cycle; issue stalls at zero credit.
//
// Optional feature: define DIV_ZERO_GUARD_EN to issue divisor-0 entries with
// out_divider forced to 1 and out_zero_flag raised alongside out_data_valid.
//
// Ports:
//   in_clk, in_reset                  clock, synchronous active-high reset
//   in_req_valid/out_req_ready        request handshake; in_dividend, in_divider payload
//   in_flush                          1-cycle pulse, discards all queued requests
//   in_credit_return                  1-cycle pulse per downstream result consumed
//   out_data_valid, out_dividend,
//   out_divider, out_zero_flag        registered issue to divider_top
//   out_fifo_count, out_credit_count  occupancy and available credits
//   out_credit_err                    sticky credit-overflow indication
module divider_issue_ctrl
  import divider_issue_ctrl_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_WIDTH_DEF,
  parameter int DIVIDER_WIDTH  = DIVIDER_WIDTH_DEF,
  parameter int FIFO_DEPTH     = 8,
  parameter int CREDITS        = 16
) (
  input  logic                         in_clk,
  input  logic                         in_reset,
  input  logic                         in_req_valid,
  output logic                         out_req_ready,
  input  logic [DIVIDEND_WIDTH-1:0]    in_dividend,
  input  logic [DIVIDER_WIDTH-1:0]     in_divider,
  input  logic                         in_flush,
  input  logic                         in_credit_return,
  output logic                         out_data_valid,
  output logic [DIVIDEND_WIDTH-1:0]    out_dividend,
  output logic [DIVIDER_WIDTH-1:0]     out_divider,
  output logic                         out_zero_flag,
  output logic [clog2(FIFO_DEPTH):0]   out_fifo_count,
  output logic [clog2(CREDITS):0]      out_credit_count,
  output logic                         out_credit_err
);

  localparam int W   = DIVIDEND_WIDTH + DIVIDER_WIDTH;
  localparam int CW  = clog2(CREDITS) + 1;
  localparam int NW  = clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

  state_t                     state;
  state_t                     state_nxt;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [NW-1:0]              fifo_count;
  logic [NW-1:0]              count_nxt;
  logic [W-1:0]               head;
  logic [DIVIDEND_WIDTH-1:0]  head_dividend;
  logic [DIVIDER_WIDTH-1:0]   head_divider;
  logic                       flushing;
  logic                       push;
  logic                       issue;
  logic                       fifo_clear;
  logic [CW-1:0]              credit_q;
  logic [CW-1:0]              credit_nxt;
  logic                       credit_err_set;

  assign flushing   = (state == S_FLUSH);
  assign fifo_clear = in_flush || flushing;

  // Ready is held low while reset is asserted so every output reads 0 then.
  assign out_req_ready = !fifo_full && !flushing && !in_reset;

  // A flush pulse wins over a request offered in the same cycle.
  assign push  = in_req_valid && out_req_ready && !in_flush;
  assign issue = !fifo_empty && (credit_q != '0) && !flushing && !in_flush;

  assign {head_dividend, head_divider} = head;

  divider_issue_ctrl_sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (in_clk),
    .reset     (in_reset),
    .clear     (fifo_clear),
    .push      (push),
    .push_data ({in_dividend, in_divider}),
    .pop       (issue),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Credit accounting. A return with the counter already at its maximum is an
  // upstream protocol error: the count saturates and the error is latched.
  // A return coinciding with an issue is a net-zero exchange and never errors.
  always_comb begin
    credit_nxt     = credit_q;
    credit_err_set = 1'b0;
    if (issue && !in_credit_return) begin
      credit_nxt = credit_q - CW'(1);
    end else if (!issue && in_credit_return) begin
      if (credit_q == CREDIT_MAX) credit_err_set = 1'b1;
      else                        credit_nxt = credit_q + CW'(1);
    end
  end

  // Occupancy after this edge (flush handled separately in the FSM).
  always_comb begin
    count_nxt = fifo_count;
    if (push && !issue)      count_nxt = fifo_count + NW'(1);
    else if (!push && issue) count_nxt = fifo_count - NW'(1);
  end

  // Next state follows from what the queue and credit counter will hold after
  // this edge: empty -> idle, entries but no credit -> stall, else issuing.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FLUSH: state_nxt = S_IDLE;
      default: begin
        if (in_flush)               state_nxt = S_FLUSH;
        else if (count_nxt == '0)   state_nxt = S_IDLE;
        else if (credit_nxt == '0)  state_nxt = S_STALL;
        else                        state_nxt = S_ISSUE;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state            <= S_IDLE;
      credit_q         <= CREDIT_MAX;
      out_credit_err   <= 1'b0;
      out_data_valid   <= 1'b0;
      out_dividend     <= '0;
      out_divider      <= '0;
    end else begin
      state          <= state_nxt;
      credit_q       <= credit_nxt;
      out_data_valid <= issue;
      if (credit_err_set) out_credit_err <= 1'b1;
      // Payload holds its last value between issues.
      if (issue) begin
        out_dividend <= head_dividend;
`ifdef DIV_ZERO_GUARD_EN
        out_divider  <= (head_divider == '0) ? DIVIDER_WIDTH'(1) : head_divider;
`else
        out_divider  <= head_divider;
`endif
      end
    end
  end

`ifdef DIV_ZERO_GUARD_EN
  // Flag is a strobe qualified by the same issue as out_data_valid.
  always_ff @(posedge in_clk) begin
    if (in_reset) out_zero_flag <= 1'b0;
    else          out_zero_flag <= issue && (head_divider == '0);
  end
`else
  assign out_zero_flag = 1'b0;
`endif

  assign out_fifo_count   = fifo_count;
  assign out_credit_count = credit_q;

endmodule
